// File: rtl/axi_cmd_slave_if.sv
// AXI4 write/read slave channels plus the command push port.
// The DUT side is "slave"; the PS/FIFO model side is "master".
interface axi_cmd_slave_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 16
);
    logic [ID_WIDTH-1:0]     s_axi_awid;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wlast;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [ID_WIDTH-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ID_WIDTH-1:0]     s_axi_arid;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ID_WIDTH-1:0]     s_axi_rid;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [DATA_WIDTH-1:0]   m_cmd_data;
    logic                    m_cmd_valid;
    logic                    m_cmd_ready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        output s_axi_rvalid,
        input  s_axi_rready,
        output m_cmd_data, m_cmd_valid,
        input  m_cmd_ready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        input  s_axi_rvalid,
        output s_axi_rready,
        input  m_cmd_data, m_cmd_valid,
        output m_cmd_ready
    );
endinterface

// File: rtl/axi_cmd_slave.sv
// AXI4 slave turning PS write bursts into a beat-per-entry command stream,
// with a STATUS/CTRL register pair on the read/write windows.
module axi_cmd_slave #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 16
) (
    input logic            s_axi_aclk,
    input logic            s_axi_areset,
    axi_cmd_slave_if.slave bus
);
    localparam logic [3:0] OFF_CMD    = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_CTRL   = 4'h2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                alive;
    logic [ID_WIDTH-1:0] w_id, r_id;
    logic [7:0]          w_len, r_len;
    logic [3:0]          w_off, r_off;
    logic [7:0]          beat_cnt, r_cnt;
    logic                w_err;
    logic [31:0]         push_count;
    logic [15:0]         err_count;

    logic awready, wready, bvalid, cmd_valid;
    logic arready, rvalid;
    logic aw_hs, w_hs, ar_hs, r_hs, push;
    logic w_is_cmd, full_strb, last_beat, beat_err;
    logic err_inc, clr;
    logic [3:0] aw_off;

    assign aw_off    = bus.s_axi_awaddr[7:4];
    assign w_is_cmd  = (w_off == OFF_CMD);
    assign full_strb = &bus.s_axi_wstrb;
    assign last_beat = (beat_cnt == w_len);
    assign beat_err  = (w_is_cmd && !full_strb) ||
                       (bus.s_axi_wlast != last_beat);

    assign aw_hs = bus.s_axi_awvalid && awready;
    assign w_hs  = bus.s_axi_wvalid && wready;
    assign ar_hs = bus.s_axi_arvalid && arready;
    assign r_hs  = rvalid && bus.s_axi_rready;
    assign push  = cmd_valid && bus.m_cmd_ready;

    assign err_inc = w_hs && last_beat && (w_err || beat_err);
    assign clr     = w_hs && (w_off == OFF_CTRL) &&
                     bus.s_axi_wdata[0] && bus.s_axi_wstrb[0];

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Partial-strobe CMD beats bypass backpressure since they are dropped.
    always_comb begin
        w_next    = w_state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        cmd_valid = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = alive;
                if (bus.s_axi_awvalid && alive) w_next = W_DATA;
            end
            W_DATA: begin
                wready    = (w_is_cmd && full_strb) ? bus.m_cmd_ready : 1'b1;
                cmd_valid = w_is_cmd && bus.s_axi_wvalid && full_strb;
                if (w_hs && last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bus.s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = alive;
                if (bus.s_axi_arvalid && alive) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (bus.s_axi_rready && (r_cnt == r_len)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            alive      <= 1'b0;
            w_id       <= '0;
            w_len      <= '0;
            w_off      <= '0;
            beat_cnt   <= '0;
            w_err      <= 1'b0;
            r_id       <= '0;
            r_len      <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            push_count <= '0;
            err_count  <= '0;
        end else begin
            alive <= 1'b1;
            if (aw_hs) begin
                w_id     <= bus.s_axi_awid;
                w_len    <= bus.s_axi_awlen;
                w_off    <= aw_off;
                beat_cnt <= '0;
                w_err    <= !((aw_off == OFF_CMD) || (aw_off == OFF_CTRL));
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                w_err    <= w_err || beat_err;
            end
            if (ar_hs) begin
                r_id  <= bus.s_axi_arid;
                r_len <= bus.s_axi_arlen;
                r_off <= bus.s_axi_araddr[7:4];
                r_cnt <= '0;
            end
            if (r_hs) r_cnt <= r_cnt + 8'd1;
            if (clr) begin
                push_count <= '0;
                err_count  <= '0;
            end else begin
                if (push) push_count <= push_count + 32'd1;
                if (err_inc && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
        end
    end

    assign bus.s_axi_awready = awready;
    assign bus.s_axi_wready  = wready;
    assign bus.s_axi_bvalid  = bvalid;
    assign bus.s_axi_bid     = w_id;
    assign bus.s_axi_bresp   = (bvalid && w_err) ? 2'b10 : 2'b00;
    assign bus.m_cmd_valid   = cmd_valid;
    assign bus.m_cmd_data    = bus.s_axi_wdata;

    assign bus.s_axi_arready = arready;
    assign bus.s_axi_rvalid  = rvalid;
    assign bus.s_axi_rid     = r_id;
    assign bus.s_axi_rlast   = rvalid && (r_cnt == r_len);
    assign bus.s_axi_rresp   = (rvalid && (r_off > OFF_CTRL)) ? 2'b10 : 2'b00;
    assign bus.s_axi_rdata   = (rvalid && (r_off == OFF_STATUS)) ?
        DATA_WIDTH'({bus.m_cmd_ready, err_count, push_count}) : '0;

    logic unused_ok;
    assign unused_ok = ^{bus.s_axi_awaddr[ADDR_WIDTH-1:8],
                         bus.s_axi_awaddr[3:0],
                         bus.s_axi_araddr[ADDR_WIDTH-1:8],
                         bus.s_axi_araddr[3:0]};
endmodule

// File: tb/tb_axi_cmd_slave.sv
// Scoreboard bench for axi_cmd_slave: directed bursts push expected
// responses into queues, a negedge monitor pops and compares.
module tb_axi_cmd_slave;
    localparam int DW = 128;
    localparam int AW = 40;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_cmd_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus();

    axi_cmd_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .bus         (bus)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] cmd_q[$];
    b_exp_t        b_q[$];
    r_exp_t        r_q[$];
    logic [31:0]   m_push = '0;
    logic [15:0]   m_err  = '0;

    function automatic void chk(string name, logic [DW-1:0] act,
                                logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void miss(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endfunction

    function automatic logic [DW-1:0] stat();
        return DW'({1'b1, m_err, m_push});
    endfunction

    always @(negedge clk) begin : monitor
        b_exp_t be;
        r_exp_t re;
        if (!rst) begin
            if (bus.m_cmd_valid && bus.m_cmd_ready) begin
                if (cmd_q.size() == 0) miss("cmd_unexpected");
                else chk("cmd_data", bus.m_cmd_data, cmd_q.pop_front());
            end
            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (b_q.size() == 0) miss("b_unexpected");
                else begin
                    be = b_q.pop_front();
                    chk("bid", DW'(bus.s_axi_bid), DW'(be.id));
                    chk("bresp", DW'(bus.s_axi_bresp), DW'(be.resp));
                end
            end
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (r_q.size() == 0) miss("r_unexpected");
                else begin
                    re = r_q.pop_front();
                    chk("rid", DW'(bus.s_axi_rid), DW'(re.id));
                    chk("rdata", bus.s_axi_rdata, re.data);
                    chk("rresp", DW'(bus.s_axi_rresp), DW'(re.resp));
                    chk("rlast", DW'(bus.s_axi_rlast), DW'(re.last));
                end
            end
        end
    end

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len);
        bit ok = 1'b0;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len;
        bus.s_axi_awvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = bus.s_axi_awready;
            @(posedge clk);
            #1;
        end
        bus.s_axi_awvalid = 1'b0;
        if (!ok) miss("aw_timeout");
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                          input logic last);
        bit ok = 1'b0;
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_wlast  = last;
        bus.s_axi_wvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = bus.s_axi_wready;
            @(posedge clk);
            #1;
        end
        bus.s_axi_wvalid = 1'b0;
        if (!ok) miss("w_timeout");
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len);
        bit ok = 1'b0;
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = bus.s_axi_arready;
            @(posedge clk);
            #1;
        end
        bus.s_axi_arvalid = 1'b0;
        if (!ok) miss("ar_timeout");
    endtask

    task automatic wr_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [DW-1:0] base,
                            input int bad_beat, input logic [1:0] resp);
        aw_send(id, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [DW-1:0]   d;
            logic [DW/8-1:0] s;
            d = base + DW'(i);
            s = (i == bad_beat) ? 16'h00FF : 16'hFFFF;
            if (addr[7:4] == 4'h0 && i != bad_beat) begin
                cmd_q.push_back(d);
                m_push++;
            end
            if (i == int'(len)) b_q.push_back('{id, resp});
            w_send(d, s, i == int'(len));
        end
        if (resp != 2'b00 && m_err != 16'hFFFF) m_err++;
    endtask

    task automatic rd_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [DW-1:0] data,
                            input logic [1:0] resp);
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back('{id, data, resp, i == int'(len)});
        ar_send(id, addr, len);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((cmd_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0 ||
                bus.s_axi_bvalid || bus.s_axi_rvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s actual=pending required=drained", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_awready"}, DW'(bus.s_axi_awready), '0);
        chk({tag, "_arready"}, DW'(bus.s_axi_arready), '0);
        chk({tag, "_wready"}, DW'(bus.s_axi_wready), '0);
        chk({tag, "_bvalid"}, DW'(bus.s_axi_bvalid), '0);
        chk({tag, "_rvalid"}, DW'(bus.s_axi_rvalid), '0);
        chk({tag, "_cmd_valid"}, DW'(bus.m_cmd_valid), '0);
        chk({tag, "_bresp_bid"}, DW'({bus.s_axi_bresp, bus.s_axi_bid}), '0);
        chk({tag, "_r_fields"}, DW'({bus.s_axi_rresp, bus.s_axi_rlast,
                                     bus.s_axi_rid}), '0);
        chk({tag, "_rdata"}, bus.s_axi_rdata, '0);
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_awready_up"}, DW'(bus.s_axi_awready), DW'(1));
        chk({tag, "_arready_up"}, DW'(bus.s_axi_arready), DW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        bus.s_axi_awid    = '0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awlen   = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wlast   = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b1;
        bus.s_axi_arid    = '0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b1;
        bus.m_cmd_ready   = 1'b1;

        check_reset_outputs("rst0");
        release_reset("rst0");

        wr_burst(16'h0011, 40'h00, 8'd3, 128'hA000_0000_0000_0000_0000_0000_0000_0010,
                 -1, 2'b00);
        drain("cmd_burst");
        rd_burst(16'h0021, 40'h10, 8'd0, stat(), 2'b00);
        drain("status_after_cmd");

        fork
            wr_burst(16'h0012, 40'h00, 8'd5, 128'hB0, -1, 2'b00);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.m_cmd_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_wready", DW'(bus.s_axi_wready), '0);
                    chk("stall_cmd_valid", DW'(bus.m_cmd_valid), DW'(1));
                    @(posedge clk);
                    #1;
                end
                bus.m_cmd_ready = 1'b1;
            end
        join
        drain("backpressure");

        wr_burst(16'h0013, 40'h30, 8'd1, 128'hC0, -1, 2'b10);
        drain("bad_offset");
        rd_burst(16'h0022, 40'h10, 8'd0, stat(), 2'b00);
        drain("status_after_bad");

        wr_burst(16'h0014, 40'h00, 8'd2, 128'hD0, 1, 2'b10);
        drain("partial_strobe");

        rd_burst(16'h0055, 40'h10, 8'd2, stat(), 2'b00);
        drain("status_burst");
        rd_burst(16'h0057, 40'h30, 8'd0, '0, 2'b10);
        rd_burst(16'h0058, 40'h20, 8'd1, '0, 2'b00);
        drain("read_other");

        wr_burst(16'h0015, 40'h10, 8'd0, 128'h5, -1, 2'b10);
        drain("write_status");
        rd_burst(16'h0023, 40'h10, 8'd0, stat(), 2'b00);
        drain("status_err3");

        wr_burst(16'h0018, 40'h20, 8'd0, 128'h1, -1, 2'b00);
        drain("ctrl_clear");
        m_push = '0;
        m_err  = '0;
        rd_burst(16'h0024, 40'h10, 8'd0, stat(), 2'b00);
        drain("status_cleared");

        fork
            wr_burst(16'h0016, 40'h00, 8'd3, 128'hE0, -1, 2'b00);
            rd_burst(16'h0066, 40'h00, 8'd3, '0, 2'b00);
        join
        drain("concurrent");

        aw_send(16'h0017, 40'h00, 8'd3);
        for (int i = 0; i < 2; i++) begin
            cmd_q.push_back(128'hF0 + DW'(i));
            w_send(128'hF0 + DW'(i), 16'hFFFF, 1'b0);
        end
        rst = 1'b1;
        m_push = '0;
        m_err  = '0;
        check_reset_outputs("rst1");
        release_reset("rst1");
        chk("rst1_cmd_q_empty", DW'(cmd_q.size()), '0);
        wr_burst(16'h0019, 40'h00, 8'd1, 128'h1230, -1, 2'b00);
        drain("post_reset_burst");
        rd_burst(16'h0025, 40'h10, 8'd0, stat(), 2'b00);
        drain("post_reset_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
